// File: rtl/count_display_mux_pkg.sv
// count_display_mux_pkg: shared display constants (segment patterns, anode codes, slot encodings)
package count_display_mux_pkg;
    typedef enum logic {UNITS = 1'b0, TENS = 1'b1} slot_t;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;
endpackage

// File: rtl/count_display_mux_seg7_decoder.sv
// seg7_decoder: 4-bit digit to active-low {g,f,e,d,c,b,a}; 10-15 blank
//   digit: value to show, seg: segment drive
module seg7_decoder
    import count_display_mux_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/count_display_mux.sv
// count_display_mux: frame-latched two-digit multiplexed 7-segment display of a 4-bit count
//   clk, rst (async, active-low), count: upstream value
//   seg/an: active-low segments/anodes, changed/frame: one-cycle pulses after each latch
module count_display_mux
    import count_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       changed,
    output logic       frame
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    logic [PW-1:0] pre;
    slot_t         digit, digit_nx;
    logic [3:0]    val, units, dig;
    logic [6:0]    dec_seg;
    logic          tens, slot_end, boundary, blank;

    assign slot_end = pre == PRE_LAST;
    // a frame ends as the tens slot hands back to units
    assign boundary = slot_end && digit == TENS;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre     <= '0;
            digit   <= UNITS;
            val     <= '0;
            frame   <= 1'b0;
            changed <= 1'b0;
        end else begin
            pre     <= slot_end ? '0 : pre + PW'(1);
            digit   <= digit_nx;
            val     <= boundary ? count : val;
            frame   <= boundary;
            changed <= boundary && count != val;
        end
    end

    always_comb begin
        digit_nx = digit;
        if (slot_end) digit_nx = digit == UNITS ? TENS : UNITS;
    end

    assign tens  = val >= 4'd10;
    assign units = tens ? val - 4'd10 : val;
    assign dig   = digit == TENS ? {3'b000, tens} : units;
    assign blank = digit == TENS && !tens && BLANK_LZ;

    seg7_decoder u_dec (.digit(dig), .seg(dec_seg));

    assign seg = blank ? SEG_BLANK : dec_seg;
    assign an  = digit == UNITS ? AN_UNITS : (blank ? AN_OFF : AN_TENS);
endmodule

// File: tb/tb_count_display_mux.sv
// tb_count_display_mux: directed scoreboard bench for count_display_mux (blanking and non-blanking instances)
module tb_count_display_mux;
    typedef struct {
        logic [3:0] v;
        logic       chg;
    } exp_t;

    localparam logic [6:0] PAT [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                         7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count = 4'd0;
    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;
    logic       chg1, chg0, frm1, frm0;
    exp_t       exp_q[$];
    logic [3:0] cur = 4'd0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    count_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_blank (
        .clk(clk), .rst(rst), .count(count),
        .seg(seg1), .an(an1), .changed(chg1), .frame(frm1)
    );

    count_display_mux #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_zero (
        .clk(clk), .rst(rst), .count(count),
        .seg(seg0), .an(an0), .changed(chg0), .frame(frm0)
    );

    function automatic int units_of(input logic [3:0] v);
        return v >= 4'd10 ? int'(v) - 10 : int'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [3:0] v, input logic chg);
        exp_t e;
        e.v = v;
        e.chg = chg;
        exp_q.push_back(e);
    endtask

    // waits for the frame pulse, checks the latched value in the first two units cycles
    task automatic check_frame(input int exp_wait);
        exp_t e;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frm1 !== 1'b1 && n < 20);
        chk("frame_seen", {31'd0, frm1}, 32'd1);
        chk("frame_lz0", {31'd0, frm0}, 32'd1);
        chk("frame_wait", n, exp_wait);
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: frame observed with no expected entry");
            return;
        end
        e = exp_q.pop_front();
        cur = e.v;
        chk("changed", {31'd0, chg1}, {31'd0, e.chg});
        chk("changed_lz0", {31'd0, chg0}, {31'd0, e.chg});
        chk("units_an", {30'd0, an1}, 32'b10);
        chk("units_seg", {25'd0, seg1}, {25'd0, PAT[units_of(e.v)]});
        chk("units_seg_lz0", {25'd0, seg0}, {25'd0, PAT[units_of(e.v)]});
        @(negedge clk);
        chk("frame_one_cycle", {31'd0, frm1}, 32'd0);
        chk("changed_one_cycle", {31'd0, chg1}, 32'd0);
        chk("units_hold", {25'd0, seg1}, {25'd0, PAT[units_of(e.v)]});
    endtask

    task automatic check_tens(input int steps);
        repeat (steps) @(negedge clk);
        if (cur >= 4'd10) begin
            chk("tens_an", {30'd0, an1}, 32'b01);
            chk("tens_seg", {25'd0, seg1}, {25'd0, PAT[1]});
        end else begin
            chk("tens_an_blank", {30'd0, an1}, 32'b11);
            chk("tens_seg_blank", {25'd0, seg1}, 32'h7f);
        end
        chk("tens_an_lz0", {30'd0, an0}, 32'b01);
        chk("tens_seg_lz0", {25'd0, seg0}, {25'd0, PAT[cur >= 4'd10 ? 1 : 0]});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, {30'd0, an1}, 32'b10);
        chk({tag, "_seg"}, {25'd0, seg1}, 32'b1000000);
        chk({tag, "_an_lz0"}, {30'd0, an0}, 32'b10);
        chk({tag, "_seg_lz0"}, {25'd0, seg0}, 32'b1000000);
        chk({tag, "_changed"}, {31'd0, chg1}, 32'd0);
        chk({tag, "_frame"}, {31'd0, frm1}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 check_reset_outputs("rst_t3");
        #9 check_reset_outputs("rst_t12");
        #7 check_reset_outputs("rst_t19");
        count = 4'd5;
        @(negedge clk);
        rst = 1'b1;
        push(4'd5, 1'b1);
        check_frame(8);
        check_tens(3);
        push(4'd5, 1'b0);
        check_frame(4);
        check_tens(3);
        count = 4'd12;
        push(4'd12, 1'b1);
        check_frame(4);
        check_tens(3);
        push(4'd12, 1'b0);
        check_frame(4);
        check_tens(3);
        count = 4'd3;
        push(4'd3, 1'b1);
        check_frame(4);
        count = 4'd9;
        push(4'd9, 1'b1);
        @(negedge clk);
        chk("no_tear", {25'd0, seg1}, {25'd0, PAT[3]});
        check_tens(2);
        check_frame(4);
        check_tens(3);
        count = 4'd4;
        @(negedge clk);
        count = 4'd9;
        push(4'd9, 1'b0);
        check_frame(3);
        check_tens(3);
        count = 4'd7;
        push(4'd7, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 count = 4'd8;
        check_frame(1);
        check_tens(3);
        push(4'd8, 1'b1);
        check_frame(4);
        check_tens(3);
        for (int i = 0; i < 9; i++) begin
            count = 4'((10 + i) % 16);
            push(4'((10 + i) % 16), 1'b1);
            check_frame(4);
            check_tens(3);
        end
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        count = 4'd4;
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b1;
        push(4'd4, 1'b1);
        check_frame(8);
        check_tens(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
